// File: rtl/divisor_frequencia_prog_if.sv
// Control and status bundle for the programmable clock-enable generator.
// The master side runs the channels and loads ratios; the slave side is
// the divider itself, which returns tick/sq/pend per channel.
interface divisor_frequencia_prog_if #(
  parameter int N_CH  = 2,
  parameter int WIDTH = 20,
  parameter int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic [N_CH-1:0]  en;
  logic             sync;
  logic             div_load;
  logic [SEL_W-1:0] div_sel;
  logic [WIDTH-1:0] div_val;
  logic [N_CH-1:0]  tick;
  logic [N_CH-1:0]  sq;
  logic [N_CH-1:0]  pend;

  modport master (
    output en, sync, div_load, div_sel, div_val,
    input  tick, sq, pend
  );

  modport slave (
    input  en, sync, div_load, div_sel, div_val,
    output tick, sq, pend
  );
endinterface

// File: rtl/divisor_frequencia_prog.sv
// Multi-channel programmable clock-enable generator. Each channel divides
// clk by a runtime-loadable ratio and emits a one-cycle tick plus a
// near-50% square wave, all as enables on the single clk domain.

// One divider channel. Ratio changes are deferred to the period boundary
// so every emitted period has either the old or the new length, never a
// truncated mix of the two.
module divisor_frequencia_prog_ch #(
  parameter int               WIDTH = 20,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [WIDTH-1:0] val,
  output logic             tick,
  output logic             sq,
  output logic             pend
);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);
  localparam logic [WIDTH-1:0] ACT_RST = (INIT < TWO) ? TWO : INIT;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] half;
  logic             wrap;

  // Ratios 0 and 1 cannot produce a distinct tick/sq phase; run them as 2.
  function automatic logic [WIDTH-1:0] clamp2(input logic [WIDTH-1:0] v);
    return (v < TWO) ? TWO : v;
  endfunction

  // act is always >= 2, so act-1 never underflows.
  assign wrap = (cnt == act - WIDTH'(1));
  // ceil(act/2): odd ratios get the extra cycle in the high phase.
  assign half = (act >> 1) + {{(WIDTH-1){1'b0}}, act[0]};

  // Counter, active ratio and deferred-load bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      act  <= ACT_RST;
      nxt  <= '0;
      pend <= 1'b0;
    end else if (!en) begin
      // Idle channel: nothing to glitch, so a load takes effect at once.
      cnt <= '0;
      if (ld) begin
        act  <= clamp2(val);
        nxt  <= val;
        pend <= 1'b0;
      end
    end else if (sync) begin
      // Phase realign wins over wrap; the ratio stays put, loads still queue.
      cnt <= '0;
      if (ld) begin
        nxt  <= val;
        pend <= 1'b1;
      end
    end else if (wrap) begin
      cnt  <= '0;
      pend <= 1'b0;
      if (ld)
        act <= clamp2(val);
      else if (pend)
        act <= clamp2(nxt);
    end else begin
      cnt <= cnt + WIDTH'(1);
      if (ld) begin
        nxt  <= val;
        pend <= 1'b1;
      end
    end
  end

  // Registered outputs decoded from the pre-edge counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= 1'b0;
      sq   <= 1'b0;
    end else begin
      tick <= en & wrap & ~sync;
      sq   <= en & (cnt < half);
    end
  end
endmodule

// Top: fans the shared load strobe out to the addressed channel and
// replicates the channel block N_CH times.
module divisor_frequencia_prog #(
  parameter int                    N_CH     = 2,
  parameter int                    WIDTH    = 20,
  parameter logic [N_CH*WIDTH-1:0] DIV_INIT = {20'd524288, 20'd262144}
) (
  input  logic                      clk,
  input  logic                      rst_n,
  divisor_frequencia_prog_if.slave  bus
);
  localparam int SEL_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] ld_w;
  logic [N_CH-1:0] tick_w;
  logic [N_CH-1:0] sq_w;
  logic [N_CH-1:0] pend_w;

  assign bus.tick = tick_w;
  assign bus.sq   = sq_w;
  assign bus.pend = pend_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    // Out-of-range selects match no channel and are dropped.
    assign ld_w[i] = bus.div_load && (bus.div_sel == SEL_W'(i));

    divisor_frequencia_prog_ch #(
      .WIDTH (WIDTH),
      .INIT  (DIV_INIT[i*WIDTH +: WIDTH])
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.en[i]),
      .sync  (bus.sync),
      .ld    (ld_w[i]),
      .val   (bus.div_val),
      .tick  (tick_w[i]),
      .sq    (sq_w[i]),
      .pend  (pend_w[i])
    );
  end
endmodule

// File: tb/tb_divisor_frequencia_prog.sv
// Scoreboard bench: the driver applies stimulus once per cycle, advances a
// period-level reference model and queues the expected outputs; an
// independent monitor pops and compares on every falling edge.
module tb_divisor_frequencia_prog;
  localparam int N = 3;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  divisor_frequencia_prog_if #(.N_CH(N), .WIDTH(W)) bus ();

  divisor_frequencia_prog #(
    .N_CH     (N),
    .WIDTH    (W),
    .DIV_INIT ({8'd5, 8'd6, 8'd4})
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [N-1:0] t;
    logic [N-1:0] s;
    logic [N-1:0] p;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: each channel is a period length plus a position
  // inside the current period, with an optional queued next period.
  int   period [N];
  int   posn   [N];
  int   queued [N];
  bit   has_q  [N];
  int   init_p [N] = '{4, 6, 5};
  logic [N-1:0] cur_en;

  function automatic int eff(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < N; c++) begin
      period[c] = eff(init_p[c]);
      posn[c]   = 0;
      queued[c] = 0;
      has_q[c]  = 0;
    end
  endfunction

  function automatic void model_step(input logic [N-1:0] e, input logic s,
                                     input logic ld, input logic [1:0] sel,
                                     input int v);
    exp_t x = '0;
    if (!rst_n) begin
      model_reset();
      q.push_back(x);
      return;
    end
    for (int c = 0; c < N; c++) begin
      bit hit  = ld && (int'(sel) == c);
      bit last = (posn[c] == period[c] - 1);
      if (!e[c]) begin
        posn[c] = 0;
        if (hit) begin
          period[c] = eff(v);
          has_q[c]  = 0;
        end
      end else begin
        x.t[c] = !s && last;
        x.s[c] = posn[c] < (period[c] + 1) / 2;
        if (s) begin
          posn[c] = 0;
          if (hit) begin queued[c] = v; has_q[c] = 1; end
        end else if (last) begin
          posn[c] = 0;
          if (hit) period[c] = eff(v);
          else if (has_q[c]) period[c] = eff(queued[c]);
          has_q[c] = 0;
        end else begin
          posn[c] = posn[c] + 1;
          if (hit) begin queued[c] = v; has_q[c] = 1; end
        end
      end
      x.p[c] = has_q[c];
    end
    q.push_back(x);
  endfunction

  // Monitor: one comparison per clock against the oldest expectation.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if (bus.tick !== x.t || bus.sq !== x.s || bus.pend !== x.p) begin
        errors++;
        $display("FAIL scoreboard @%0t: got tick=%b sq=%b pend=%b, want tick=%b sq=%b pend=%b",
                 $time, bus.tick, bus.sq, bus.pend, x.t, x.s, x.p);
      end
    end
  end

  // One clock of stimulus; called just after a falling edge.
  task automatic cyc(input logic s, input logic ld, input logic [1:0] sel, input int v);
    bus.en       = cur_en;
    bus.sync     = s;
    bus.div_load = ld;
    bus.div_sel  = sel;
    bus.div_val  = W'(v);
    @(posedge clk);
    model_step(cur_en, s, ld, sel, v);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 0);
  endtask

  task automatic load(input logic [1:0] sel, input int v);
    cyc(1'b0, 1'b1, sel, v);
  endtask

  // Advance until the model says channel ch sits at position p (bounded).
  task automatic run_to(input int ch, input int p);
    int n = 0;
    while (posn[ch] != p && n < 64) begin
      idle(1);
      n++;
    end
    checks++;
    if (posn[ch] != p) begin
      errors++;
      $display("FAIL run_to ch%0d: position %0d, wanted %0d within 64 cycles", ch, posn[ch], p);
    end
  endtask

  // Asynchronous reset placed between clock edges.
  task automatic areset(input int hold);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    checks++;
    if (bus.tick !== '0 || bus.sq !== '0 || bus.pend !== '0) begin
      errors++;
      $display("FAIL async_reset: got tick=%b sq=%b pend=%b, want all zero",
               bus.tick, bus.sq, bus.pend);
    end
    model_reset();
    @(negedge clk);
    cur_en = '0;
    idle(hold);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    cur_en = '0;
    bus.en = '0; bus.sync = 1'b0; bus.div_load = 1'b0;
    bus.div_sel = '0; bus.div_val = '0;
    model_reset();
    @(negedge clk);
    areset(3);

    // Reset ratios 4/6, both channels running.
    idle(2);
    cur_en = 3'b011;
    idle(30);

    // Odd ratio, then the clamp for 0 and 1.
    load(2'd0, 5);
    idle(15);
    load(2'd0, 0);
    idle(10);
    load(2'd0, 1);
    idle(10);

    // Deferred reload mid-period, then a load landing on the wrap.
    load(2'd0, 4);
    idle(10);
    run_to(0, 1);
    load(2'd0, 8);
    idle(14);
    run_to(0, 7);
    load(2'd0, 4);
    idle(10);

    // sync with ch1 on its wrap state and ch0 mid-period.
    run_to(1, 5);
    cyc(1'b1, 1'b0, 2'd0, 0);
    idle(30);

    // Disable ch1, reprogram it idle, re-enable.
    run_to(1, 2);
    cur_en = 3'b001;
    idle(3);
    load(2'd1, 3);
    idle(2);
    cur_en = 3'b011;
    idle(15);

    // Pending load interrupted by an asynchronous reset.
    run_to(0, 0);
    load(2'd0, 9);
    idle(1);
    areset(2);
    cur_en = 3'b111;
    idle(20);

    // Out-of-range select is ignored.
    load(2'd3, 2);
    idle(4);
    load(2'd3, 0);
    idle(20);

    // Randomized loads, enables and syncs.
    for (int i = 0; i < 800; i++) begin
      logic s, ld;
      if ($urandom_range(0, 19) == 0) cur_en = N'($urandom_range(0, 7));
      s  = ($urandom_range(0, 29) == 0);
      ld = ($urandom_range(0, 3) == 0);
      cyc(s, ld, 2'($urandom_range(0, 3)), $urandom_range(0, 15));
    end

    idle(2);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
